mgia_vram_arbiter: RTL

Two-master arbiter sharing the MGIA video RAM port between the MGIA line-fetch engine and the CPU bus. The video master has priority so scan-out never underruns. A saturating starvation counter guarantees the CPU a grant within a bounded time. The block sits between the MGIA fetch unit, the CPU-side Wishbone interconnect, and the single-ported video RAM, all in the CLK_I_50MHZ domain.

---
 rtl/mgia_pkg.sv | 13 +
 rtl/mgia_starve_ctr.sv | 30 +++
 rtl/mgia_vram_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mgia_pkg.sv
// Shared definitions for the MGIA video RAM arbiter: state encoding and default bus widths.
package mgia_pkg;

    localparam int MGIA_AW = 15;
    localparam int MGIA_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mgia_starve_ctr.sv
// Saturating CPU starvation counter; starve rises once the CPU has waited MAX_WAIT cycles.
module mgia_starve_ctr #(
    parameter int MAX_WAIT = 32,
    parameter int WAIT_W   = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starve
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_count;

    // Clear wins over increment: the grant cycle itself still has the request pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count < MAX_CNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_starve = (r_count >= MAX_CNT);

endmodule

// File: rtl/mgia_vram_arbiter.sv
// Two-master video RAM arbiter: video fetch has priority, CPU is protected by a starvation counter.
module mgia_vram_arbiter
    import mgia_pkg::*;
#(
    parameter int AW       = MGIA_AW,
    parameter int DW       = MGIA_DW,
    parameter int MAX_WAIT = 32,
    parameter int WAIT_W   = 6
) (
    input  logic            CLK_I_50MHZ,
    input  logic            RST_I,
    input  logic            V_CYC_I,
    input  logic            V_STB_I,
    input  logic [AW-1:0]   V_ADR_I,
    output logic            V_ACK_O,
    output logic [DW-1:0]   V_DAT_O,
    input  logic            C_CYC_I,
    input  logic            C_STB_I,
    input  logic            C_WE_I,
    input  logic [AW-1:0]   C_ADR_I,
    input  logic [DW-1:0]   C_DAT_I,
    input  logic [DW/8-1:0] C_SEL_I,
    output logic            C_ACK_O,
    output logic [DW-1:0]   C_DAT_O,
    output logic            M_CYC_O,
    output logic            M_STB_O,
    output logic            M_WE_O,
    output logic [AW-1:0]   M_ADR_O,
    output logic [DW-1:0]   M_DAT_O,
    output logic [DW/8-1:0] M_SEL_O,
    input  logic            M_ACK_I,
    input  logic [DW-1:0]   M_DAT_I,
    output logic [1:0]      GNT_O
);

    arb_state_t r_state;
    logic [1:0] r_gnt;

    logic w_vreq;
    logic w_creq;
    logic w_starve;
    logic w_cpu_inc;
    logic w_cpu_entry;

    assign w_vreq = V_CYC_I & V_STB_I;
    assign w_creq = C_CYC_I & C_STB_I;

    // The CPU is taken from IDLE either when starving or when video is not asking.
    assign w_cpu_entry = (r_state == ST_IDLE) && w_creq && (w_starve || !w_vreq);
    assign w_cpu_inc   = w_creq && (r_state != ST_CPU);

    mgia_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve_ctr (
        .i_clk    (CLK_I_50MHZ),
        .i_rst    (RST_I),
        .i_inc    (w_cpu_inc),
        .i_clr    (w_cpu_entry),
        .o_starve (w_starve)
    );

    always_ff @(posedge CLK_I_50MHZ or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_starve && w_creq) begin
                        r_state <= ST_CPU;
                        r_gnt   <= 2'b10;
                    end else if (w_vreq) begin
                        r_state <= ST_VID;
                        r_gnt   <= 2'b01;
                    end else if (w_creq) begin
                        r_state <= ST_CPU;
                        r_gnt   <= 2'b10;
                    end
                end
                // A grant lasts exactly one Wishbone cycle; dropping CYC releases the bus.
                ST_VID: begin
                    if (!V_CYC_I) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                ST_CPU: begin
                    if (!C_CYC_I) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        M_CYC_O = 1'b0;
        M_STB_O = 1'b0;
        M_WE_O  = 1'b0;
        M_ADR_O = '0;
        M_DAT_O = '0;
        M_SEL_O = '0;
        case (r_state)
            ST_VID: begin
                M_CYC_O = V_CYC_I;
                M_STB_O = V_STB_I;
                M_ADR_O = V_ADR_I;
                M_SEL_O = '1;
            end
            ST_CPU: begin
                M_CYC_O = C_CYC_I;
                M_STB_O = C_STB_I;
                M_WE_O  = C_WE_I;
                M_ADR_O = C_ADR_I;
                M_DAT_O = C_DAT_I;
                M_SEL_O = C_SEL_I;
            end
            default: begin
                M_CYC_O = 1'b0;
            end
        endcase
    end

    assign V_ACK_O = M_ACK_I & (r_state == ST_VID);
    assign C_ACK_O = M_ACK_I & (r_state == ST_CPU);
    assign V_DAT_O = M_DAT_I;
    assign C_DAT_O = M_DAT_I;
    assign GNT_O   = r_gnt;

endmodule
